dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-outstanding data-memory line port among NUM_REQ requesters,
//  for example I$ refill (port 0) and D$ refill/writeback (port 1).
//  Arbitration is round-robin. One transaction is in flight at a time.
//  Each memory response is returned only to the requester that issued it.
//  Sits between the caches and the memory model; all memory traffic passes through it.
// PARAMETERS
//  NUM_REQ      2     number of requesters (>=2)
//  TIMEOUT_CYC  64    WAIT cycles after which err_o[0] (timeout) sets
// PORTS
//  clk_i            in   1            clock
//  rst_i            in   1            synchronous reset, active-high
//  req_valid_i      in   NUM_REQ      per-requester request valid
//  req_ready_o      out  NUM_REQ      per-requester request accepted (one-hot or 0)
//  req_addr_i       in   NUM_REQ*32   request byte address, slice i = [32*i+:32]
//  req_we_i         in   NUM_REQ      1 = line write, 0 = line read
//  req_data_i       in   NUM_REQ*128  write line, slice i = [128*i+:128]
//  rsp_valid_o      out  NUM_REQ      response valid, owner bit only
//  rsp_ready_i      in   NUM_REQ      per-requester response ready
//  rsp_addr_o       out  32           response line address (shared)
//  rsp_data_o       out  128          response line data (shared)
//  mem_req_valid_o  out  1            memory request valid
//  mem_req_ready_i  in   1            memory request ready
//  mem_addr_o       out  32           memory address
//  mem_we_o         out  1            memory write enable
//  mem_data_wr_o    out  128          memory write line
//  mem_rsp_valid_i  in   1            memory response valid
//  mem_rsp_ready_o  out  1            memory response ready
//  mem_rsp_addr_i   in   32           memory response line address
//  mem_rsp_data_i   in   128          memory response line data
//  busy_o           out  1            state != IDLE
//  grant_id_o       out  $clog2(NUM_REQ)  owner of the current transaction
//  err_o            out  2            sticky: [0] timeout, [1] spurious response
// BEHAVIOUR
//  Reset (rst_i high at a posedge):
//   - state=IDLE; rr_ptr=0; owner=0; latched addr/we/data=0; timeout counter=0; err_o=0.
//   - All outputs are 0 except mem_rsp_ready_o, which is 1 because the state is IDLE.
//   - Reset mid-transaction abandons it. A response arriving later is treated as spurious.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE:
//   - Selects the first valid requester searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - Drives req_ready_o one-hot to that requester only.
//   - On the handshake, latches addr/we/data and owner, then goes to ISSUE.
//   - mem_rsp_ready_o=1. Any mem_rsp_valid_i in IDLE is dropped and sets err_o[1].
//  ISSUE:
//   - mem_req_valid_o=1 with the latched fields; addr is passed unmodified.
//   - Fields hold stable until mem_req_ready_i. Then clear the counter and go to WAIT.
//  WAIT:
//   - rsp_valid_o[owner]=mem_rsp_valid_i; rsp_addr_o/rsp_data_o = mem_rsp_*.
//   - mem_rsp_ready_o = rsp_ready_i[owner]; the response path is combinational, zero latency.
//   - On the handshake: rr_ptr=(owner+1) mod NUM_REQ, then go to IDLE.
//   - Writes also complete with a response, which is forwarded and must be consumed.
//   - Counter increments each WAIT cycle and saturates at TIMEOUT_CYC.
//     Reaching it sets err_o[0]. The FSM stays in WAIT; there is no abort.
//  Request latency: accepted at cycle N, mem_req_valid_o=1 at cycle N+1.
//  A new request is accepted no earlier than the cycle after the response handshake.
//  rsp_valid_o bits for non-owners are always 0. rsp_addr_o/rsp_data_o are don't-care
//  outside WAIT but are driven from mem_rsp_* (no X).
//  Requesters must hold req_* stable while valid and not ready.
// TESTING
//  1. After reset, req_valid_i=2'b01, addr0=0x100, we0=0:
//     -> req_ready_o=01 at cycle 0; mem_req_valid_o at cycle 1 with addr 0x100;
//     -> response data returned on rsp_valid_o=01 only.
//  2. Both requesters valid continuously, 4 transactions:
//     -> grants follow 0,1,0,1; grant_id_o matches; req_ready_o is never 2'b11.
//  3. Requester 1 writes line 0xDEADBEEF_... to 0x200; rsp_ready_i[1] held low 3 cycles:
//     -> mem_rsp_ready_o stays 0 until rsp_ready_i[1] rises;
//     -> mem_we_o=1 and mem_data_wr_o equals the written line.
//  4. mem_req_ready_i held low 5 cycles in ISSUE:
//     -> mem_addr_o/mem_we_o/mem_data_wr_o stable; req_ready_o stays 00.
//  5. mem_rsp_valid_i withheld 64+ cycles in WAIT (TIMEOUT_CYC=64):
//     -> err_o[0] sets at WAIT cycle 64 and stays 1 after the late response completes.
//  6. Assert rst_i during WAIT, then inject mem_rsp_valid_i in IDLE:
//     -> outputs return to reset values; the response is dropped; err_o[1]=1;
//     -> no rsp_valid_o bit is asserted.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request, response and memory-side bundle for dmem_arbiter
interface dmem_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]     req_valid_i;
   logic [NUM_REQ-1:0]     req_ready_o;
   logic [NUM_REQ*32-1:0]  req_addr_i;
   logic [NUM_REQ-1:0]     req_we_i;
   logic [NUM_REQ*128-1:0] req_data_i;
   logic [NUM_REQ-1:0]     rsp_valid_o;
   logic [NUM_REQ-1:0]     rsp_ready_i;
   logic [31:0]            rsp_addr_o;
   logic [127:0]           rsp_data_o;
   logic                   mem_req_valid_o;
   logic                   mem_req_ready_i;
   logic [31:0]            mem_addr_o;
   logic                   mem_we_o;
   logic [127:0]           mem_data_wr_o;
   logic                   mem_rsp_valid_i;
   logic                   mem_rsp_ready_o;
   logic [31:0]            mem_rsp_addr_i;
   logic [127:0]           mem_rsp_data_i;

   // slave: the arbiter itself; master: the caches plus the memory model around it
   modport slave (
      input  req_valid_i, req_addr_i, req_we_i, req_data_i, rsp_ready_i,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_addr_i, mem_rsp_data_i,
      output req_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o,
      output mem_req_valid_o, mem_addr_o, mem_we_o, mem_data_wr_o, mem_rsp_ready_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_we_i, req_data_i, rsp_ready_i,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_addr_i, mem_rsp_data_i,
      input  req_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o,
      input  mem_req_valid_o, mem_addr_o, mem_we_o, mem_data_wr_o, mem_rsp_ready_o
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-outstanding memory line port
module dmem_arbiter #(
   parameter int  NUM_REQ     = 2,
   parameter int  TIMEOUT_CYC = 64,
   localparam int GW          = $clog2(NUM_REQ),
   localparam int CW          = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   dmem_arbiter_if.slave bus,
   output logic          busy_o,
   output logic [GW-1:0] grant_id_o,
   output logic [1:0]    err_o
);
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0] owner_q, owner_d;
   logic [31:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [127:0]  data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    err_q, err_d;
   logic          mem_req_valid_q, mem_req_valid_d;
   logic          busy_q, busy_d;

   logic          sel_found;
   logic [GW-1:0] sel_idx;
   logic [GW-1:0] cand;
   logic          rsp_hs;

   // Round-robin search starting at rr_ptr_q
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!sel_found && bus.req_valid_i[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   always_comb begin
      bus.req_ready_o = '0;
      if (state_q == ST_IDLE && sel_found) begin
         bus.req_ready_o[sel_idx] = 1'b1;
      end
      bus.rsp_valid_o = '0;
      if (state_q == ST_WAIT) begin
         bus.rsp_valid_o[owner_q] = bus.mem_rsp_valid_i;
      end
      case (state_q)
         ST_IDLE: bus.mem_rsp_ready_o = 1'b1;
         ST_WAIT: bus.mem_rsp_ready_o = bus.rsp_ready_i[owner_q];
         default: bus.mem_rsp_ready_o = 1'b0;
      endcase
   end

   assign rsp_hs          = (state_q == ST_WAIT) && bus.mem_rsp_valid_i && bus.mem_rsp_ready_o;
   assign bus.rsp_addr_o  = bus.mem_rsp_addr_i;
   assign bus.rsp_data_o  = bus.mem_rsp_data_i;
   assign bus.mem_req_valid_o = mem_req_valid_q;
   assign bus.mem_addr_o      = addr_q;
   assign bus.mem_we_o        = we_q;
   assign bus.mem_data_wr_o   = data_q;
   assign busy_o          = busy_q;
   assign grant_id_o      = owner_q;
   assign err_o           = err_q;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      we_d     = we_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            // Memory never has a legitimate response pending while idle
            if (bus.mem_rsp_valid_i) begin
               err_d[1] = 1'b1;
            end
            if (sel_found) begin
               owner_d = sel_idx;
               addr_d  = bus.req_addr_i[32*sel_idx +: 32];
               we_d    = bus.req_we_i[sel_idx];
               data_d  = bus.req_data_i[128*sel_idx +: 128];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.mem_req_ready_i) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (rsp_hs) begin
               rr_ptr_d = GW'((int'(owner_q) + 1) % NUM_REQ);
               state_d  = ST_IDLE;
            end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == CW'(TIMEOUT_CYC)) begin
                  err_d[0] = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      mem_req_valid_d = (state_d == ST_ISSUE);
      busy_d          = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         rr_ptr_q        <= '0;
         owner_q         <= '0;
         addr_q          <= '0;
         we_q            <= 1'b0;
         data_q          <= '0;
         cnt_q           <= '0;
         err_q           <= '0;
         mem_req_valid_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         owner_q         <= owner_d;
         addr_q          <= addr_d;
         we_q            <= we_d;
         data_q          <= data_d;
         cnt_q           <= cnt_d;
         err_q           <= err_d;
         mem_req_valid_q <= mem_req_valid_d;
         busy_q          <= busy_d;
      end
   end
endmodule
